// File: rtl/gate_chk_pkg.sv
// Shared types, sizes and reference model for the gate response checkers.
package gate_chk_pkg;

   localparam int unsigned VEC_W = 4;
   localparam int unsigned RSP_W = 3;
   localparam int unsigned NPAT  = 16;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   // Expected {g,f,e} for stim {d,c,b,a}: e = a|b, f = c|d, g = a|b|c|d
   function automatic logic [RSP_W-1:0] exp_rsp(input logic [VEC_W-1:0] stim);
      logic e;
      logic f;
      logic g;
      e = stim[0] | stim[1];
      f = stim[2] | stim[3];
      g = e | f;
      return {g, f, e};
   endfunction

endpackage

// File: rtl/gate_ref_model.sv
// Combinational reference response for one stimulus vector.
module gate_ref_model
   import gate_chk_pkg::*;
(
   input  logic [VEC_W-1:0] stim,
   output logic [RSP_W-1:0] rsp_exp
);

   assign rsp_exp = exp_rsp(stim);

endmodule

// File: rtl/gate_response_checker.sv
// Run-based response checker: compares gate outputs to the reference model,
// counts mismatches, records the first failure and tracks pattern coverage.
module gate_response_checker
   import gate_chk_pkg::*;
#(
   parameter int unsigned ERR_W   = 8,
   parameter int unsigned TIMEOUT = 64
)(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             in_valid,
   input  logic [VEC_W-1:0] stim,
   input  logic [RSP_W-1:0] rsp,
   output logic             busy,
   output logic             done,
   output logic             pass,
   output logic [ERR_W-1:0] err_cnt,
   output logic [NPAT-1:0]  cov_mask,
   output logic             first_err_valid,
   output logic [VEC_W-1:0] first_err_stim,
   output logic [RSP_W-1:0] first_err_rsp
);

   localparam int unsigned IDLE_W = $clog2(TIMEOUT + 1);

   state_t             state;
   state_t             state_d;
   logic [VEC_W-1:0]   stim_q;
   logic [RSP_W-1:0]   rsp_q;
   logic               vld_q;
   logic               vld_d;
   logic [IDLE_W-1:0]  idle_cnt;
   logic [IDLE_W-1:0]  idle_d;
   logic [ERR_W-1:0]   err_d;
   logic [NPAT-1:0]    cov_d;
   logic               fe_valid_d;
   logic [VEC_W-1:0]   fe_stim_d;
   logic [RSP_W-1:0]   fe_rsp_d;
   logic               pass_d;
   logic [RSP_W-1:0]   rsp_exp;
   logic               mismatch;

   gate_ref_model u_ref (
      .stim    (stim_q),
      .rsp_exp (rsp_exp)
   );

   assign mismatch = vld_q && (rsp_q != rsp_exp);

   // Next state: start only honoured outside RUN
   always_comb begin
      state_d = state;
      case (state)
         IDLE:    if (start) state_d = RUN;
         RUN:     if (cov_mask == '1 || idle_cnt >= IDLE_W'(TIMEOUT)) state_d = DONE;
         DONE:    if (start) state_d = RUN;
         default: state_d = IDLE;
      endcase
   end

   // Result update; a pair captured as the run closes is dropped
   always_comb begin
      err_d      = err_cnt;
      cov_d      = cov_mask;
      fe_valid_d = first_err_valid;
      fe_stim_d  = first_err_stim;
      fe_rsp_d   = first_err_rsp;
      idle_d     = idle_cnt;
      vld_d      = in_valid && (state == RUN) && (state_d == RUN);
      if (start && state != RUN) begin
         err_d      = '0;
         cov_d      = '0;
         fe_valid_d = 1'b0;
         fe_stim_d  = '0;
         fe_rsp_d   = '0;
         idle_d     = '0;
      end else begin
         if (state == RUN) begin
            if (in_valid)
               idle_d = '0;
            else if (idle_cnt < IDLE_W'(TIMEOUT))
               idle_d = idle_cnt + IDLE_W'(1);
         end
         if (vld_q) begin
            cov_d[stim_q] = 1'b1;
            if (mismatch) begin
               if (err_cnt != '1) err_d = err_cnt + ERR_W'(1);
               if (!first_err_valid) begin
                  fe_valid_d = 1'b1;
                  fe_stim_d  = stim_q;
                  fe_rsp_d   = rsp_q;
               end
            end
         end
      end
      pass_d = (state_d == DONE) && (err_d == '0) && (cov_d == '1);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state           <= IDLE;
         stim_q          <= '0;
         rsp_q           <= '0;
         vld_q           <= 1'b0;
         idle_cnt        <= '0;
         err_cnt         <= '0;
         cov_mask        <= '0;
         first_err_valid <= 1'b0;
         first_err_stim  <= '0;
         first_err_rsp   <= '0;
         busy            <= 1'b0;
         done            <= 1'b0;
         pass            <= 1'b0;
      end else begin
         state           <= state_d;
         stim_q          <= stim;
         rsp_q           <= rsp;
         vld_q           <= vld_d;
         idle_cnt        <= idle_d;
         err_cnt         <= err_d;
         cov_mask        <= cov_d;
         first_err_valid <= fe_valid_d;
         first_err_stim  <= fe_stim_d;
         first_err_rsp   <= fe_rsp_d;
         busy            <= (state_d == RUN);
         done            <= (state_d == DONE);
         pass            <= pass_d;
      end
   end

endmodule

// File: tb/tb_gate_response_checker.sv
// Directed bench for gate_response_checker with hand-computed expectations.
module tb_gate_response_checker;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start;
   logic        in_valid;
   logic [3:0]  stim;
   logic [2:0]  rsp;
   logic        busy;
   logic        done;
   logic        pass;
   logic [7:0]  err_cnt;
   logic [15:0] cov_mask;
   logic        first_err_valid;
   logic [3:0]  first_err_stim;
   logic [2:0]  first_err_rsp;

   int vectors = 0;
   int miscompares = 0;

   // {g,f,e} for stim 0..15
   logic [2:0] rsp_tab [16];

   gate_response_checker #(.ERR_W(8), .TIMEOUT(64)) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .start           (start),
      .in_valid        (in_valid),
      .stim            (stim),
      .rsp             (rsp),
      .busy            (busy),
      .done            (done),
      .pass            (pass),
      .err_cnt         (err_cnt),
      .cov_mask        (cov_mask),
      .first_err_valid (first_err_valid),
      .first_err_stim  (first_err_stim),
      .first_err_rsp   (first_err_rsp)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      step();
      start = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; stim = '0; rsp = '0;
      #12;
      vectors++;
      if ({busy, done, pass, first_err_valid} !== 4'b0000) begin
         miscompares++;
         $display("FAIL reset_flags got %b want 0000", {busy, done, pass, first_err_valid});
      end
      vectors++;
      if ({err_cnt, cov_mask, first_err_stim, first_err_rsp} !== 31'd0) begin
         miscompares++;
         $display("FAIL reset_data got err=%h cov=%h fs=%h fr=%h want all 0", err_cnt, cov_mask, first_err_stim, first_err_rsp);
      end
      rst_n = 1'b1;
      step();
      // pairs in IDLE must be ignored
      in_valid = 1'b1; rsp = 3'b010;
      for (int i = 0; i < 4; i++) begin
         stim = 4'(i);
         step();
      end
      in_valid = 1'b0;
      step();
      vectors++;
      if (err_cnt !== 8'd0 || cov_mask !== 16'd0 || busy !== 1'b0) begin
         miscompares++;
         $display("FAIL idle_ignore got err=%h cov=%h busy=%b want 0/0/0", err_cnt, cov_mask, busy);
      end
   endtask

   task automatic sweep(input logic inject, input logic want_pass);
      pulse_start();
      vectors++;
      if (busy !== 1'b1 || cov_mask !== 16'd0 || err_cnt !== 8'd0) begin
         miscompares++;
         $display("FAIL sweep_start got busy=%b cov=%h err=%h want 1/0000/00", busy, cov_mask, err_cnt);
      end
      in_valid = 1'b1;
      for (int i = 0; i < 16; i++) begin
         stim = 4'(i);
         rsp  = (inject && i == 5) ? 3'b011 : rsp_tab[i];
         step();
      end
      in_valid = 1'b0;
      step();
      vectors++;
      if (done !== 1'b0 || cov_mask !== 16'hFFFF) begin
         miscompares++;
         $display("FAIL sweep_pre_done got done=%b cov=%h want 0/ffff", done, cov_mask);
      end
      step();
      vectors++;
      if (done !== 1'b1 || busy !== 1'b0 || pass !== want_pass) begin
         miscompares++;
         $display("FAIL sweep_done got done=%b busy=%b pass=%b want 1/0/%b", done, busy, pass, want_pass);
      end
      vectors++;
      if (err_cnt !== (inject ? 8'd1 : 8'd0) || cov_mask !== 16'hFFFF) begin
         miscompares++;
         $display("FAIL sweep_counts got err=%h cov=%h want %h/ffff", err_cnt, cov_mask, inject ? 8'd1 : 8'd0);
      end
      vectors++;
      if (inject ? {first_err_valid, first_err_stim, first_err_rsp} !== {1'b1, 4'h5, 3'b011}
                 : first_err_valid !== 1'b0) begin
         miscompares++;
         $display("FAIL sweep_first_err got v=%b s=%h r=%b inject=%b", first_err_valid, first_err_stim, first_err_rsp, inject);
      end
   endtask

   task automatic test_done_restart();
      // in DONE after an error sweep: pairs ignored
      in_valid = 1'b1; rsp = 3'b010;
      for (int i = 0; i < 5; i++) begin
         stim = 4'(i);
         step();
      end
      in_valid = 1'b0;
      step();
      vectors++;
      if (err_cnt !== 8'd1 || cov_mask !== 16'hFFFF || done !== 1'b1) begin
         miscompares++;
         $display("FAIL done_ignore got err=%h cov=%h done=%b want 01/ffff/1", err_cnt, cov_mask, done);
      end
      pulse_start();
      vectors++;
      if ({busy, done, pass, first_err_valid} !== 4'b1000 || err_cnt !== 8'd0 || cov_mask !== 16'd0
          || first_err_stim !== 4'd0 || first_err_rsp !== 3'd0) begin
         miscompares++;
         $display("FAIL done_restart got flags=%b err=%h cov=%h fs=%h fr=%b want 1000/0/0/0/0",
                  {busy, done, pass, first_err_valid}, err_cnt, cov_mask, first_err_stim, first_err_rsp);
      end
   endtask

   task automatic test_timeout();
      pulse_start();
      in_valid = 1'b1;
      for (int i = 0; i < 8; i++) begin
         stim = 4'(i);
         rsp  = rsp_tab[i];
         step();
      end
      in_valid = 1'b0;
      for (int i = 0; i < 64; i++) step();
      vectors++;
      if (done !== 1'b0 || busy !== 1'b1) begin
         miscompares++;
         $display("FAIL timeout_early got done=%b busy=%b want 0/1", done, busy);
      end
      step();
      vectors++;
      if (done !== 1'b1 || pass !== 1'b0 || cov_mask !== 16'h00FF || err_cnt !== 8'd0) begin
         miscompares++;
         $display("FAIL timeout_done got done=%b pass=%b cov=%h err=%h want 1/0/00ff/00", done, pass, cov_mask, err_cnt);
      end
   endtask

   task automatic test_saturate();
      pulse_start();
      in_valid = 1'b1;
      rsp = 3'b010;
      for (int i = 0; i < 300; i++) begin
         stim = 4'((i % 15) + 1);
         step();
      end
      in_valid = 1'b0;
      step();
      step();
      vectors++;
      if (err_cnt !== 8'hFF || busy !== 1'b1) begin
         miscompares++;
         $display("FAIL sat_count got err=%h busy=%b want ff/1", err_cnt, busy);
      end
      vectors++;
      if ({first_err_valid, first_err_stim, first_err_rsp} !== {1'b1, 4'h1, 3'b010}) begin
         miscompares++;
         $display("FAIL sat_first_err got v=%b s=%h r=%b want 1/1/010", first_err_valid, first_err_stim, first_err_rsp);
      end
      for (int i = 0; i < 64; i++) step();
      vectors++;
      if (done !== 1'b1 || pass !== 1'b0 || cov_mask !== 16'hFFFE || err_cnt !== 8'hFF) begin
         miscompares++;
         $display("FAIL sat_done got done=%b pass=%b cov=%h err=%h want 1/0/fffe/ff", done, pass, cov_mask, err_cnt);
      end
   endtask

   task automatic test_restart_reset();
      pulse_start();
      in_valid = 1'b1;
      for (int i = 0; i < 10; i++) begin
         stim  = 4'(i);
         rsp   = rsp_tab[i];
         start = (i == 6);
         step();
      end
      start = 1'b0;
      in_valid = 1'b0;
      step();
      vectors++;
      if (cov_mask !== 16'h03FF || busy !== 1'b1 || err_cnt !== 8'd0) begin
         miscompares++;
         $display("FAIL run_start_ignored got cov=%h busy=%b err=%h want 03ff/1/00", cov_mask, busy, err_cnt);
      end
      in_valid = 1'b1; stim = 4'hA; rsp = 3'b000;
      step();
      step();
      #1;
      rst_n = 1'b0;
      #2;
      vectors++;
      if ({busy, done, pass, first_err_valid} !== 4'b0000 || err_cnt !== 8'd0 || cov_mask !== 16'd0
          || first_err_stim !== 4'd0 || first_err_rsp !== 3'd0) begin
         miscompares++;
         $display("FAIL async_reset got flags=%b err=%h cov=%h fs=%h fr=%b want all 0",
                  {busy, done, pass, first_err_valid}, err_cnt, cov_mask, first_err_stim, first_err_rsp);
      end
      in_valid = 1'b0;
      #3;
      rst_n = 1'b1;
      step();
      sweep(1'b0, 1'b1);
   endtask

   initial begin
      rsp_tab[0]  = 3'b000; rsp_tab[1]  = 3'b101; rsp_tab[2]  = 3'b101; rsp_tab[3]  = 3'b101;
      rsp_tab[4]  = 3'b110; rsp_tab[5]  = 3'b111; rsp_tab[6]  = 3'b111; rsp_tab[7]  = 3'b111;
      rsp_tab[8]  = 3'b110; rsp_tab[9]  = 3'b111; rsp_tab[10] = 3'b111; rsp_tab[11] = 3'b111;
      rsp_tab[12] = 3'b110; rsp_tab[13] = 3'b111; rsp_tab[14] = 3'b111; rsp_tab[15] = 3'b111;
      test_reset();
      sweep(1'b0, 1'b1);
      sweep(1'b1, 1'b0);
      test_done_restart();
      test_timeout();
      test_saturate();
      test_restart_reset();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
